multicycle_ctrl: RTL
====================

# multicycle_ctrl

Moore-style control unit for the multicycle processor datapath. Sequences instruction fetch, decode, execute, memory access and write-back for a reduced MIPS subset. Drives every datapath mux selector, including a 3-bit `mem_to_reg` for the 5-input register write-data mux, plus all register and memory write enables. It sits between the instruction register fields, the ALU zero flag, and the datapath.

## Interface
- No parameters. All encodings come from the shared defines header.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `opcode` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load qualified by `zero`.
- `pc_source` out 2: 00 ALU result, 01 ALUOut, 10 jump target {PC[31:28],IR[25:0],00}, 11 register A.
- `i_or_d` out 1: memory address, 0 PC, 1 ALUOut.
- `mem_wr` out 1: memory write.
- `ir_wr` out 1: instruction register load.
- `mdr_wr` out 1: memory data register load.
- `a_b_wr` out 1: load A/B from the register file.
- `alu_out_wr` out 1: ALUOut load.
- `reg_wr` out 1: register file write.
- `reg_dst` out 2: 00 rt, 01 rd, 10 $31, 11 $29.
- `mem_to_reg` out 3: 000 ALUOut, 001 MDR, 010 imm<<16, 011 PC, 100 constant 227.
- `alu_src_a` out 1: 0 PC, 1 A.
- `alu_src_b` out 2: 00 B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- `alu_op` out 3: 000 add, 001 sub, 010 and.
- `illegal` out 1: one-cycle pulse on an unsupported opcode or funct.

## Operation
- Outputs are decoded purely from the current state. Every output not listed for a state is 0.
- **RST** (held while `reset`=1): all outputs 0. Next state is SP_INIT.
- **SP_INIT**: `reg_wr`=1, `reg_dst`=11, `mem_to_reg`=100, so $29 = 227. Next state is F0.
- **F0, F1**: `i_or_d`=0. Memory has 1-cycle read latency, so F1 is the wait state.
- **F2**: `ir_wr`=1; `alu_src_a`=0, `alu_src_b`=01, add; `pc_write`=1, `pc_source`=00.
- **DEC**: `a_b_wr`=1, `alu_out_wr`=1, `alu_src_a`=0, `alu_src_b`=11, add. Dispatches on opcode:
  - 0x00 with funct 0x20/0x22/0x24 goes to R_EX; funct 0x08 goes to JR; any other funct goes to ILL.
  - 0x08 goes to ADDI_EX.
  - 0x23 and 0x2B go to ADDR.
  - 0x04 goes to BEQ.
  - 0x02 goes to J.
  - 0x03 goes to JAL.
  - 0x0F goes to LUI.
  - Anything else goes to ILL.
- **R_EX**: `alu_src_a`=1, `alu_src_b`=00, `alu_op` from funct (add/sub/and), `alu_out_wr`=1. Next state is R_WB.
- **R_WB**: `reg_wr`, `reg_dst`=01, `mem_to_reg`=000.
- **ADDI_EX**: A + sext, `alu_out_wr`. Next state is ADDI_WB.
- **ADDI_WB**: `reg_wr`, `reg_dst`=00, `mem_to_reg`=000.
- **ADDR**: A + sext, `alu_out_wr`. Next state is LW_R0 for 0x23, SW for 0x2B.
- **LW_R0, LW_R1**: `i_or_d`=1.
- **LW_MDR**: `i_or_d`=1, `mdr_wr`=1.
- **LW_WB**: `reg_wr`, `reg_dst`=00, `mem_to_reg`=001.
- **SW**: `i_or_d`=1, `mem_wr`=1.
- **BEQ**: A − B, `pc_write_cond`=1, `pc_source`=01.
- **J**: `pc_write`, `pc_source`=10.
- **JR**: `pc_write`, `pc_source`=11.
- **JAL**: `reg_wr`, `reg_dst`=10, `mem_to_reg`=011, `pc_write`, `pc_source`=10.
  - The register file samples PC before it updates, so $31 receives PC+4.
- **LUI**: `reg_wr`, `reg_dst`=00, `mem_to_reg`=010.
- **ILL**: `illegal`=1, no writes.
- All terminal states (R_WB, ADDI_WB, LW_WB, SW, BEQ, J, JR, JAL, LUI, ILL) return to F0.

## Timing
- Cycles per instruction, counted from F0 entry to the next F0 entry:
  - R-type: 6
  - addi: 6
  - lw: 9
  - sw: 6
  - beq, j, jr, jal, lui: 5
  - illegal: 5
- `opcode` and `funct` are sampled only in DEC, R_EX and ADDR. The IR is stable by then because it was loaded in F2.
- `zero` is used combinationally only in BEQ. The datapath gates the PC load with `pc_write_cond & zero`.
- Reset asserted mid-instruction: the state goes to RST immediately and all outputs drop to 0 asynchronously. No partial write completes after the assertion edge.
- After reset deassertion:
  - The first clock edge enters SP_INIT.
  - The second edge enters F0.
  - SP_INIT runs exactly once per reset release.
- An unused state encoding goes to RST on the next edge.

## Structure
- Shared header `ctrl_defs.vh` holds:
  - opcode and funct constants;
  - the state encodings (5-bit);
  - `pc_source`, `reg_dst`, `mem_to_reg`, `alu_src_b` and `alu_op` selector constants.
- The datapath muxes include the same header.
- No sub-module: a single state register, a next-state case and an output decode case.
- The 5-input write-data mux widens its selector to 3 bits to match `mem_to_reg`.

## Test plan
- **Reset release**: hold `reset` 3 cycles, then drop it.
  - Required: all outputs 0 during reset.
  - The next cycle shows `reg_wr`=1, `reg_dst`=11, `mem_to_reg`=100.
  - F0 follows, with `i_or_d`=0.
- **add** (opcode 0x00, funct 0x20):
  - `ir_wr` in cycle 3, `pc_write` in cycle 3.
  - `alu_op`=000 with `alu_src_a`=1 in cycle 5.
  - `reg_wr` with `reg_dst`=01 in cycle 6; next F0 in cycle 7.
- **lw** (0x23):
  - `i_or_d`=1 in cycles 6–8.
  - `mdr_wr` in cycle 8.
  - `reg_wr` with `mem_to_reg`=001 in cycle 9.
  - **sw** (0x2B): `mem_wr`=1 only in cycle 6.
- **beq** (0x04): `alu_op`=001, `pc_write_cond`=1, `pc_source`=01 in cycle 5, checked with both `zero`=1 and `zero`=0.
  - **jal** (0x03): `reg_wr`, `reg_dst`=10, `mem_to_reg`=011, `pc_write`, `pc_source`=10 all in one cycle.
- **Illegal encodings**: opcode 0x3F, then opcode 0x00 with funct 0x01.
  - Required: each gives a one-cycle `illegal` pulse in cycle 5, with no `reg_wr`, `mem_wr` or `pc_write` in that instruction after F2.
- **Reset mid-instruction**: assert `reset` in LW_R1.
  - Required: `i_or_d` and all other outputs go to 0 without a clock edge.
  - The SP_INIT then F0 sequence restarts on release.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control unit and the datapath muxes it drives:
// opcodes, functs, 5-bit state codes and every selector value.
package multicycle_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REGA   = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;
    localparam logic [1:0] REGDST_SP = 2'b11;

    // Register write-data mux: 5 inputs, hence a 3-bit selector.
    localparam logic [2:0] WD_ALUOUT  = 3'b000;
    localparam logic [2:0] WD_MDR     = 3'b001;
    localparam logic [2:0] WD_LUI     = 3'b010;
    localparam logic [2:0] WD_PC      = 3'b011;
    localparam logic [2:0] WD_SP_INIT = 3'b100;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;

    typedef enum logic [4:0] {
        S_RST = 5'd0, S_SP_INIT, S_F0, S_F1, S_F2, S_DEC,
        S_R_EX, S_R_WB, S_ADDI_EX, S_ADDI_WB, S_ADDR,
        S_LW_R0, S_LW_R1, S_LW_MDR, S_LW_WB, S_SW,
        S_BEQ, S_J, S_JR, S_JAL, S_LUI, S_ILL
    } state_t;

    function automatic logic [2:0] alu_op_for_funct(input logic [5:0] fn);
        case (fn)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Moore control unit for the multicycle MIPS-subset datapath: one state register,
// a next-state case and a pure state-to-outputs decode.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_wr,
    output logic       ir_wr,
    output logic       mdr_wr,
    output logic       a_b_wr,
    output logic       alu_out_wr,
    output logic       reg_wr,
    output logic [1:0] reg_dst,
    output logic [2:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       illegal
);

    state_t state_q, state_d;

    // The datapath gates the PC load with pc_write_cond & zero; the controller never needs it.
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_RST;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_RST;
        case (state_q)
            S_RST:     state_d = S_SP_INIT;
            S_SP_INIT: state_d = S_F0;
            S_F0:      state_d = S_F1;
            S_F1:      state_d = S_F2;
            S_F2:      state_d = S_DEC;
            S_DEC: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND) state_d = S_R_EX;
                        else if (funct == FN_JR) state_d = S_JR;
                        else                     state_d = S_ILL;
                    end
                    OP_ADDI:     state_d = S_ADDI_EX;
                    OP_LW, OP_SW: state_d = S_ADDR;
                    OP_BEQ:      state_d = S_BEQ;
                    OP_J:        state_d = S_J;
                    OP_JAL:      state_d = S_JAL;
                    OP_LUI:      state_d = S_LUI;
                    default:     state_d = S_ILL;
                endcase
            end
            S_R_EX:    state_d = S_R_WB;
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_ADDR:    state_d = (opcode == OP_LW) ? S_LW_R0 : S_SW;
            S_LW_R0:   state_d = S_LW_R1;
            S_LW_R1:   state_d = S_LW_MDR;
            S_LW_MDR:  state_d = S_LW_WB;
            S_R_WB, S_ADDI_WB, S_LW_WB, S_SW, S_BEQ,
            S_J, S_JR, S_JAL, S_LUI, S_ILL: state_d = S_F0;
            default:   state_d = S_RST;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        i_or_d        = 1'b0;
        mem_wr        = 1'b0;
        ir_wr         = 1'b0;
        mdr_wr        = 1'b0;
        a_b_wr        = 1'b0;
        alu_out_wr    = 1'b0;
        reg_wr        = 1'b0;
        reg_dst       = REGDST_RT;
        mem_to_reg    = WD_ALUOUT;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        illegal       = 1'b0;
        case (state_q)
            S_SP_INIT: begin
                reg_wr     = 1'b1;
                reg_dst    = REGDST_SP;
                mem_to_reg = WD_SP_INIT;
            end
            S_F2: begin
                ir_wr     = 1'b1;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            S_DEC: begin
                a_b_wr     = 1'b1;
                alu_out_wr = 1'b1;
                alu_src_b  = SRCB_IMM_SH2;
            end
            S_R_EX: begin
                alu_src_a  = 1'b1;
                alu_op     = alu_op_for_funct(funct);
                alu_out_wr = 1'b1;
            end
            S_ADDI_EX, S_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_out_wr = 1'b1;
            end
            S_R_WB: begin
                reg_wr  = 1'b1;
                reg_dst = REGDST_RD;
            end
            S_ADDI_WB: reg_wr = 1'b1;
            S_LW_R0, S_LW_R1: i_or_d = 1'b1;
            S_LW_MDR: begin
                i_or_d = 1'b1;
                mdr_wr = 1'b1;
            end
            S_LW_WB: begin
                reg_wr     = 1'b1;
                mem_to_reg = WD_MDR;
            end
            S_SW: begin
                i_or_d = 1'b1;
                mem_wr = 1'b1;
            end
            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_J: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            S_JR: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_REGA;
            end
            // The register file samples PC before this edge updates it, so $31 gets PC+4.
            S_JAL: begin
                reg_wr     = 1'b1;
                reg_dst    = REGDST_RA;
                mem_to_reg = WD_PC;
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
            end
            S_LUI: begin
                reg_wr     = 1'b1;
                mem_to_reg = WD_LUI;
            end
            S_ILL:   illegal = 1'b1;
            default: ;
        endcase
    end

endmodule
